// File: rtl/mlp_train_sequencer_pkg.sv
// Shared types for the MLP training sequencer: fixed-point sample type and FSM states.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package mlp_train_sequencer_pkg;

    // ---------------------------------------------------------------- FixedPoint
    // Signed Q8.8 fixed point used for features, targets, predictions and learning rate.
    typedef logic signed [15:0] sfp;

    localparam sfp ZERO = 16'sh0000;
    localparam sfp ONE  = 16'sh0100;

    // ---------------------------------------------------------------- Common
    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_MEM,
        SETTLE,
        UPDATE,
        ADVANCE,
        FINISH
    } seq_state_t;

    // Sample address width; a single-sample dataset still needs one address bit.
    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Halve a learning rate, never letting a nonzero rate collapse to zero.
    function automatic sfp lr_halve(input sfp lr);
        sfp half;
        half = lr >>> 1;
        if (lr != ZERO && half == ZERO) begin
            return sfp'(16'sd1);
        end
        return half;
    endfunction

endpackage

// File: rtl/mlp_train_sequencer.sv
// Steps an MLP through a sample dataset: fetch sample, settle, sample prediction, optionally train, per epoch.
// Latency: 1 (fetch) + 1 + mem wait (wait) + settle_cycles + 1 (train only) + 1 (advance) cycles per sample.
// Backpressure: stalls indefinitely in WAIT_MEM until mem_valid; start is ignored while busy.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset (aborts any run, no resume)
//   start, train_mode,  run request; mode/epoch count/learning rate latched when start is
//   epochs, base_lr     accepted in IDLE (epochs==0 runs one epoch)
//   busy, done          busy outside IDLE; done is a one-cycle pulse at the end of a run
//   mem_*               one-cycle read request at mem_addr, response qualified by mem_valid
//   mlp_*               registered sample/target to the network, train strobe, learning rate
//   result_*            captured prediction per sample with its address
//   epoch_count         completed epochs of the current/last run (saturating)
//
// Build option: define MLP_LR_DECAY_EN to halve the learning rate at every epoch wrap
// (floored at 1 LSB for a nonzero base rate). Without it the rate stays at base_lr.
module mlp_train_sequencer
    import mlp_train_sequencer_pkg::*;
#(
    parameter  int inputs        = 2,
    parameter  int outputs       = 1,
    parameter  int num_samples   = 4,
    parameter  int settle_cycles = 2,
    localparam int AW            = addr_width(num_samples)
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   start,
    input  logic                   train_mode,
    input  logic [15:0]            epochs,
    input  sfp                     base_lr,
    output logic                   busy,
    output logic                   done,

    output logic [AW-1:0]          mem_addr,
    output logic                   mem_rd,
    input  logic                   mem_valid,
    input  sfp   [inputs-1:0]      mem_values,
    input  sfp   [outputs-1:0]     mem_expected,

    output sfp   [inputs-1:0]      mlp_values,
    output sfp   [outputs-1:0]     mlp_expected,
    output logic                   mlp_training,
    output sfp                     mlp_learning_rate,
    input  sfp   [outputs-1:0]     mlp_prediction,

    output logic                   result_valid,
    output logic [AW-1:0]          result_addr,
    output sfp   [outputs-1:0]     result,
    output logic [15:0]            epoch_count
);

    localparam logic [3:0]    SETTLE_LOAD = 4'(settle_cycles);
    localparam logic [AW-1:0] LAST_IDX    = AW'(num_samples - 1);

    seq_state_t    state;
    seq_state_t    state_nxt;

    logic [AW-1:0] sample_idx;
    logic [3:0]    settle_cnt;
    logic          train_q;
    logic [15:0]   epochs_q;

    logic          last_settle;
    logic          last_sample;
    logic [15:0]   eff_epochs;
    logic [15:0]   epoch_inc;
    logic          run_complete;

    assign last_settle = (settle_cnt == 4'd1);
    assign last_sample = (sample_idx == LAST_IDX);
    assign eff_epochs  = (epochs_q == 16'd0) ? 16'd1 : epochs_q;
    assign epoch_inc   = (epoch_count == 16'hFFFF) ? epoch_count : epoch_count + 16'd1;
    // An inference pass always ends after its first sweep; training ends when the
    // post-wrap epoch count reaches the requested number of epochs.
    assign run_complete = last_sample && (!train_q || (epoch_inc == eff_epochs));

    // ------------------------------------------------------------ state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------ next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start)       state_nxt = FETCH;
            FETCH:                     state_nxt = WAIT_MEM;
            WAIT_MEM: if (mem_valid)   state_nxt = SETTLE;
            SETTLE:   if (last_settle) state_nxt = train_q ? UPDATE : ADVANCE;
            UPDATE:                    state_nxt = ADVANCE;
            ADVANCE:                   state_nxt = run_complete ? FINISH : FETCH;
            FINISH:                    state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------ state outputs
    // Decoded straight from the state register so an asynchronous reset drops
    // mlp_training in the same cycle and aborts any weight update.
    always_comb begin
        busy         = 1'b1;
        mem_rd       = 1'b0;
        mlp_training = 1'b0;
        done         = 1'b0;
        case (state)
            IDLE:    busy         = 1'b0;
            FETCH:   mem_rd       = 1'b1;
            UPDATE:  mlp_training = 1'b1;
            FINISH:  done         = 1'b1;
            default: ;
        endcase
    end

    assign mem_addr = sample_idx;

    // ------------------------------------------------------------ datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_idx        <= '0;
            settle_cnt        <= '0;
            train_q           <= 1'b0;
            epochs_q          <= '0;
            epoch_count       <= '0;
            mlp_values        <= '{default: ZERO};
            mlp_expected      <= '{default: ZERO};
            mlp_learning_rate <= ZERO;
            result_valid      <= 1'b0;
            result_addr       <= '0;
            result            <= '{default: ZERO};
        end else begin
            result_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        train_q           <= train_mode;
                        epochs_q          <= epochs;
                        mlp_learning_rate <= base_lr;
                        sample_idx        <= '0;
                        epoch_count       <= '0;
                    end
                end
                WAIT_MEM: begin
                    if (mem_valid) begin
                        mlp_values   <= mem_values;
                        mlp_expected <= mem_expected;
                        settle_cnt   <= SETTLE_LOAD;
                    end
                end
                SETTLE: begin
                    settle_cnt <= settle_cnt - 4'd1;
                    if (last_settle) begin
                        result       <= mlp_prediction;
                        result_valid <= 1'b1;
                        result_addr  <= sample_idx;
                    end
                end
                ADVANCE: begin
                    if (last_sample) begin
                        sample_idx  <= '0;
                        epoch_count <= epoch_inc;
`ifdef MLP_LR_DECAY_EN
                        mlp_learning_rate <= lr_halve(mlp_learning_rate);
`endif
                    end else begin
                        sample_idx <= sample_idx + AW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mlp_train_sequencer.sv
// Directed bench for mlp_train_sequencer: table-driven memory model, adder "network",
// negedge monitor logging strobes, one task per scenario with inline comparisons.
module tb_mlp_train_sequencer;
    import mlp_train_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        train_mode = 1'b0;
    logic [15:0] epochs = 16'd0;
    sfp          base_lr = ONE;
    logic        busy, done;
    logic [1:0]  mem_addr;
    logic        mem_rd;
    logic        mem_valid = 1'b0;
    sfp   [1:0]  mem_values;
    sfp   [0:0]  mem_expected;
    sfp   [1:0]  mlp_values;
    sfp   [0:0]  mlp_expected;
    logic        mlp_training;
    sfp          mlp_learning_rate;
    sfp   [0:0]  mlp_prediction;
    logic        result_valid;
    logic [1:0]  result_addr;
    sfp   [0:0]  result;
    logic [15:0] epoch_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic slow = 1'b0;       // stall the response for sample 2 by 7 cycles
    int   dly  = 0;

    always #5 clk = ~clk;

    mlp_train_sequencer #(
        .inputs(2), .outputs(1), .num_samples(4), .settle_cycles(2)
    ) dut (
        .clk(clk), .rst(rst),
        .start(start), .train_mode(train_mode), .epochs(epochs), .base_lr(base_lr),
        .busy(busy), .done(done),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_valid(mem_valid),
        .mem_values(mem_values), .mem_expected(mem_expected),
        .mlp_values(mlp_values), .mlp_expected(mlp_expected),
        .mlp_training(mlp_training), .mlp_learning_rate(mlp_learning_rate),
        .mlp_prediction(mlp_prediction),
        .result_valid(result_valid), .result_addr(result_addr), .result(result),
        .epoch_count(epoch_count)
    );

    // Dataset (Q8.8) and hand-computed prediction = v0 + v1.
    function automatic sfp tbl_v0(input int a);
        case (a)
            0: return 16'sh0100;
            1: return 16'sh0080;
            2: return 16'sh0400;
            default: return 16'sh7F00;
        endcase
    endfunction
    function automatic sfp tbl_v1(input int a);
        case (a)
            0: return 16'sh0200;
            1: return 16'shFF00;
            2: return 16'sh0010;
            default: return 16'sh0005;
        endcase
    endfunction
    function automatic sfp tbl_exp(input int a);
        case (a)
            0: return 16'sh0101;
            1: return 16'sh0202;
            2: return 16'sh0303;
            default: return 16'sh0404;
        endcase
    endfunction
    function automatic sfp tbl_pred(input int a);
        case (a)
            0: return 16'sh0300;
            1: return 16'shFF80;
            2: return 16'sh0410;
            default: return 16'sh7F05;
        endcase
    endfunction

    assign mlp_prediction[0] = sfp'(mlp_values[0] + mlp_values[1]);

    // Memory responder: zero-wait (valid the cycle after mem_rd) unless stalled.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_valid <= 1'b0;
            dly       <= 0;
        end else begin
            mem_valid <= 1'b0;
            if (mem_rd) begin
                mem_values[0]   <= tbl_v0(int'(mem_addr));
                mem_values[1]   <= tbl_v1(int'(mem_addr));
                mem_expected[0] <= tbl_exp(int'(mem_addr));
                if (slow && mem_addr == 2'd2) dly <= 7;
                else                          mem_valid <= 1'b1;
            end else if (dly != 0) begin
                if (dly == 1) mem_valid <= 1'b1;
                dly <= dly - 1;
            end
        end
    end

    // Monitor: cumulative counts and logs, sampled on the falling edge.
    int cyc = 0, busy_cyc = 0, done_cnt = 0, train_cnt = 0, rv_cnt = 0;
    int rd2_cyc = 0, rv2_cyc = 0;
    sfp         lr_log  [128];
    logic [1:0] rva_log [128];
    sfp         rvr_log [128];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (busy) busy_cyc <= busy_cyc + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (mlp_training) begin
            if (train_cnt < 128) lr_log[train_cnt] <= mlp_learning_rate;
            train_cnt <= train_cnt + 1;
        end
        if (result_valid) begin
            if (rv_cnt < 128) begin
                rva_log[rv_cnt] <= result_addr;
                rvr_log[rv_cnt] <= result[0];
            end
            rv_cnt <= rv_cnt + 1;
        end
        if (mem_rd && mem_addr == 2'd2) rd2_cyc <= cyc;
        if (result_valid && result_addr == 2'd2) rv2_cyc <= cyc;
    end

    // Pulse start, then wait (bounded) for busy to fall; fin reports completion.
    task automatic do_run(input logic tm, input logic [15:0] ep, output bit fin);
        @(negedge clk);
        train_mode = tm;
        epochs     = ep;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        fin   = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (!busy) begin
                fin = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        #3;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (done !== 1'b0 || mem_rd !== 1'b0 || mlp_training !== 1'b0 || result_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_strobes got done=%b rd=%b trn=%b rv=%b want 0", done, mem_rd, mlp_training, result_valid);
        end
        n_checks++; if (epoch_count !== 16'd0 || mem_addr !== 2'd0 || result_addr !== 2'd0) begin
            n_fail++; $display("FAIL reset_counts got ep=%0d addr=%0d raddr=%0d want 0", epoch_count, mem_addr, result_addr);
        end
        n_checks++; if (mlp_values !== 32'h0 || mlp_expected !== 16'h0 || result !== 16'h0 || mlp_learning_rate !== ZERO) begin
            n_fail++; $display("FAIL reset_data got v=%h e=%h r=%h lr=%h want 0", mlp_values, mlp_expected, result, mlp_learning_rate);
        end
        #10 rst = 1'b0;
    endtask

    task automatic test_train_epochs();
        bit fin;
        int t0, d0, b0;
        sfp exp_lr;
        t0 = train_cnt; d0 = done_cnt; b0 = busy_cyc;
        base_lr = ONE;
        do_run(1'b1, 16'd3, fin);
        n_checks++; if (!fin) begin n_fail++; $display("FAIL train_timeout got busy=%b want 0", busy); end
        n_checks++; if (train_cnt - t0 !== 12) begin n_fail++; $display("FAIL train_pulses got %0d want 12", train_cnt - t0); end
        n_checks++; if (epoch_count !== 16'd3) begin n_fail++; $display("FAIL train_epoch_count got %0d want 3", epoch_count); end
        n_checks++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL train_done got %0d want 1", done_cnt - d0); end
        n_checks++; if (busy_cyc - b0 !== 73) begin n_fail++; $display("FAIL train_latency got %0d want 73", busy_cyc - b0); end
        for (int i = 0; i < 12; i++) begin
`ifdef MLP_LR_DECAY_EN
            exp_lr = ONE >>> (i / 4);
`else
            exp_lr = ONE;
`endif
            n_checks++; if (lr_log[t0 + i] !== exp_lr) begin
                n_fail++; $display("FAIL train_lr[%0d] got %h want %h", i, lr_log[t0 + i], exp_lr);
            end
        end
        n_checks++; if (mlp_values[0] !== 16'sh7F00 || mlp_values[1] !== 16'sh0005 || mlp_expected[0] !== 16'sh0404) begin
            n_fail++; $display("FAIL train_hold_last got v=%h e=%h want 00057f00/0404", mlp_values, mlp_expected);
        end
    endtask

    task automatic test_inference();
        bit fin;
        int t0, r0, b0, d0;
        t0 = train_cnt; r0 = rv_cnt; b0 = busy_cyc; d0 = done_cnt;
        do_run(1'b0, 16'd5, fin);
        n_checks++; if (!fin) begin n_fail++; $display("FAIL infer_timeout got busy=%b want 0", busy); end
        n_checks++; if (rv_cnt - r0 !== 4) begin n_fail++; $display("FAIL infer_results got %0d want 4", rv_cnt - r0); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (rva_log[r0 + i] !== 2'(i) || rvr_log[r0 + i] !== tbl_pred(i)) begin
                n_fail++; $display("FAIL infer_result[%0d] got addr=%0d val=%h want addr=%0d val=%h",
                                   i, rva_log[r0 + i], rvr_log[r0 + i], i, tbl_pred(i));
            end
        end
        n_checks++; if (train_cnt - t0 !== 0) begin n_fail++; $display("FAIL infer_training got %0d want 0", train_cnt - t0); end
        n_checks++; if (epoch_count !== 16'd1) begin n_fail++; $display("FAIL infer_epoch_count got %0d want 1", epoch_count); end
        n_checks++; if (busy_cyc - b0 !== 21 || done_cnt - d0 !== 1) begin
            n_fail++; $display("FAIL infer_len got busy=%0d done=%0d want 21/1", busy_cyc - b0, done_cnt - d0);
        end
    endtask

    task automatic test_epochs_zero();
        bit fin;
        int t0;
        t0 = train_cnt;
        do_run(1'b1, 16'd0, fin);
        n_checks++; if (!fin || train_cnt - t0 !== 4) begin
            n_fail++; $display("FAIL epochs_zero_pulses got fin=%0d n=%0d want 1/4", fin, train_cnt - t0);
        end
        n_checks++; if (epoch_count !== 16'd1) begin n_fail++; $display("FAIL epochs_zero_count got %0d want 1", epoch_count); end
    endtask

    task automatic test_mem_stall();
        bit fin;
        int r0, b0;
        r0 = rv_cnt; b0 = busy_cyc;
        slow = 1'b1;
        do_run(1'b0, 16'd1, fin);
        slow = 1'b0;
        n_checks++; if (!fin) begin n_fail++; $display("FAIL stall_timeout got busy=%b want 0", busy); end
        n_checks++; if (rv2_cyc - rd2_cyc !== 11) begin
            n_fail++; $display("FAIL stall_rd_to_result got %0d cycles want 11", rv2_cyc - rd2_cyc);
        end
        n_checks++; if (busy_cyc - b0 !== 28) begin n_fail++; $display("FAIL stall_len got %0d want 28", busy_cyc - b0); end
        n_checks++; if (rv_cnt - r0 !== 4 || rvr_log[r0 + 2] !== tbl_pred(2)) begin
            n_fail++; $display("FAIL stall_result got n=%0d val=%h want 4/%h", rv_cnt - r0, rvr_log[r0 + 2], tbl_pred(2));
        end
    endtask

    task automatic test_start_while_busy();
        bit fin;
        int t0, b0, d0;
        t0 = train_cnt; b0 = busy_cyc; d0 = done_cnt;
        @(negedge clk);
        train_mode = 1'b1; epochs = 16'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        train_mode = 1'b0; epochs = 16'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        fin = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (!busy) begin fin = 1'b1; break; end
            @(negedge clk);
        end
        n_checks++; if (!fin) begin n_fail++; $display("FAIL busy_start_timeout got busy=%b want 0", busy); end
        n_checks++; if (train_cnt - t0 !== 8) begin n_fail++; $display("FAIL busy_start_pulses got %0d want 8", train_cnt - t0); end
        n_checks++; if (busy_cyc - b0 !== 49 || done_cnt - d0 !== 1) begin
            n_fail++; $display("FAIL busy_start_len got busy=%0d done=%0d want 49/1", busy_cyc - b0, done_cnt - d0);
        end
        n_checks++; if (epoch_count !== 16'd2) begin n_fail++; $display("FAIL busy_start_epochs got %0d want 2", epoch_count); end
    endtask

    task automatic test_reset_in_update();
        bit seen;
        int d0;
        d0 = done_cnt;
        @(negedge clk);
        train_mode = 1'b1; epochs = 16'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (mlp_training) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL rst_upd_no_update got trn=%b want 1", mlp_training); end
        rst = 1'b1;
        #1;
        n_checks++; if (mlp_training !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rst_upd_abort got trn=%b busy=%b want 0/0", mlp_training, busy);
        end
        n_checks++; if (epoch_count !== 16'd0 || mlp_values !== 32'h0) begin
            n_fail++; $display("FAIL rst_upd_clear got ep=%0d v=%h want 0/0", epoch_count, mlp_values);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        n_checks++; if (busy !== 1'b0 || done_cnt - d0 !== 0) begin
            n_fail++; $display("FAIL rst_upd_no_resume got busy=%b done=%0d want 0/0", busy, done_cnt - d0);
        end
    endtask

    initial begin
        test_reset();
        test_train_epochs();
        test_inference();
        test_epochs_zero();
        test_mem_stall();
        test_start_while_busy();
        test_reset_in_update();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
